// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// cpu_pkg : state codes, opcode constants and defaults for the CPU sequencer
// Revision: 1.0
// ============================================================================
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_t;

  localparam logic [6:0] OP_BL        = 7'd0;
  localparam logic [6:0] OP_BEQ       = 7'd1;
  localparam logic [6:0] OP_BRA       = 7'd8;
  localparam logic [6:0] OP_ALU_FIRST = 7'd9;
  localparam logic [6:0] OP_CMP       = 7'd14;
  localparam logic [6:0] OP_BIT       = 7'd18;
  localparam logic [6:0] OP_ALU_LAST  = 7'd32;
  localparam logic [6:0] OP_LD        = 7'd33;
  localparam logic [6:0] OP_ST        = 7'd34;
  localparam logic [6:0] OP_MOVL      = 7'd35;
  localparam logic [6:0] OP_MOVH      = 7'd38;
  localparam logic [6:0] OP_LDR       = 7'd39;
  localparam logic [6:0] OP_STR       = 7'd40;
  localparam logic [6:0] OP_BKPT      = 7'd41;

  localparam int MEM_TIMEOUT_DEFAULT = 15;

  function automatic logic is_load(input logic [6:0] op);
    return (op == OP_LD) || (op == OP_LDR);
  endfunction

  function automatic logic is_store(input logic [6:0] op);
    return (op == OP_ST) || (op == OP_STR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_sequencer_if.sv
`default_nettype none
// ============================================================================
// cpu_sequencer_if : decoder/memory handshake and control strobes of the sequencer
// Revision: 1.0
// ============================================================================
interface cpu_sequencer_if;

  logic       Run;
  logic [6:0] OP;
  logic       FLT;
  logic       MemRdy;
  logic       BrTaken;

  logic       MemRd;
  logic       MemWr;
  logic       MemAddrSel;
  logic       IRLoad;
  logic       E;
  logic       PCInc;
  logic       PCLoad;
  logic       ALUEn;
  logic       RegWE;
  logic       Halted;
  logic       Fault;
  logic [2:0] State;

  modport master (
    input  Run, OP, FLT, MemRdy, BrTaken,
    output MemRd, MemWr, MemAddrSel, IRLoad, E, PCInc, PCLoad, ALUEn, RegWE,
           Halted, Fault, State
  );

  modport slave (
    output Run, OP, FLT, MemRdy, BrTaken,
    input  MemRd, MemWr, MemAddrSel, IRLoad, E, PCInc, PCLoad, ALUEn, RegWE,
           Halted, Fault, State
  );

endinterface
`default_nettype wire

// File: rtl/mem_wait_timer.sv
`default_nettype none
// ============================================================================
// mem_wait_timer : saturating wait-cycle counter with limit compare
// Revision: 1.0
// ============================================================================
module mem_wait_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] limit,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && (count < limit)) begin
      count <= count + WIDTH'(1);
    end
  end

  assign expired = (count >= limit);

endmodule
`default_nettype wire

// File: rtl/cpu_sequencer.sv
`default_nettype none
// ============================================================================
// cpu_sequencer : multi-cycle fetch/decode/exec/mem/writeback control sequencer
// Revision: 1.0
// ============================================================================
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input  logic            Clock,
  input  logic            Reset,
  cpu_sequencer_if.master bus
);

  localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

  state_t     state;
  state_t     next_state;
  state_t     boundary;
  logic [6:0] op_q;
  logic       fault;
  logic       fault_next;

  logic mem_rd, mem_wr, addr_sel, ir_load, dec_en, pc_inc, pc_load, alu_en, reg_we;
  logic wait_clear, wait_en, wait_expired;

  mem_wait_timer #(
    .WIDTH (WAIT_W)
  ) u_wait (
    .clk     (Clock),
    .rst     (Reset),
    .clear   (wait_clear),
    .enable  (wait_en),
    .limit   (WAIT_LIMIT),
    .expired (wait_expired)
  );

  always_comb begin
    next_state = state;
    fault_next = fault;
    boundary   = bus.Run ? ST_FETCH : ST_IDLE;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    addr_sel   = 1'b0;
    ir_load    = 1'b0;
    dec_en     = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    alu_en     = 1'b0;
    reg_we     = 1'b0;

    case (state)
      ST_IDLE: begin
        if (bus.Run) next_state = ST_FETCH;
      end

      ST_FETCH: begin
        if (wait_expired) begin
          next_state = ST_HALT;
          fault_next = 1'b1;
        end else begin
          mem_rd = 1'b1;
          if (bus.MemRdy) begin
            ir_load    = 1'b1;
            pc_inc     = 1'b1;
            next_state = ST_DECODE;
          end
        end
      end

      ST_DECODE: begin
        dec_en     = 1'b1;
        next_state = ST_EXEC;
      end

      // EXEC classifies on the live decoder outputs; FLT outranks any opcode
      ST_EXEC: begin
        if (bus.FLT || (bus.OP > OP_BKPT)) begin
          next_state = ST_HALT;
          fault_next = 1'b1;
        end else if (bus.OP <= OP_BRA) begin
          pc_load    = ((bus.OP == OP_BL) || (bus.OP == OP_BRA)) ? 1'b1 : bus.BrTaken;
          next_state = boundary;
        end else if (bus.OP <= OP_ALU_LAST) begin
          alu_en     = 1'b1;
          next_state = ST_WB;
        end else if (is_load(bus.OP) || is_store(bus.OP)) begin
          next_state = ST_MEM;
        end else if (bus.OP == OP_BKPT) begin
          next_state = ST_HALT;
        end else begin
          next_state = ST_WB;
        end
      end

      ST_MEM: begin
        if (wait_expired) begin
          next_state = ST_HALT;
          fault_next = 1'b1;
        end else begin
          addr_sel = 1'b1;
          mem_rd   = is_load(op_q);
          mem_wr   = is_store(op_q);
          if (bus.MemRdy) next_state = is_load(op_q) ? ST_WB : boundary;
        end
      end

      ST_WB: begin
        reg_we     = (op_q != OP_CMP) && (op_q != OP_BIT);
        next_state = boundary;
      end

      ST_HALT: begin
        next_state = ST_HALT;
      end

      default: begin
        next_state = ST_HALT;
        fault_next = 1'b1;
      end
    endcase

    if (Reset) begin
      mem_rd   = 1'b0;
      mem_wr   = 1'b0;
      addr_sel = 1'b0;
      ir_load  = 1'b0;
      dec_en   = 1'b0;
      pc_inc   = 1'b0;
      pc_load  = 1'b0;
      alu_en   = 1'b0;
      reg_we   = 1'b0;
    end

    // Any state change restarts the wait count, so FETCH/MEM always begin at zero
    wait_clear = (next_state != state);
    wait_en    = ((state == ST_FETCH) || (state == ST_MEM)) && !bus.MemRdy && !wait_expired;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= ST_IDLE;
      op_q  <= '0;
      fault <= 1'b0;
    end else begin
      state <= next_state;
      fault <= fault_next;
      if (state == ST_DECODE) op_q <= bus.OP;
    end
  end

  assign bus.MemRd      = mem_rd;
  assign bus.MemWr      = mem_wr;
  assign bus.MemAddrSel = addr_sel;
  assign bus.IRLoad     = ir_load;
  assign bus.E          = dec_en;
  assign bus.PCInc      = pc_inc;
  assign bus.PCLoad     = pc_load;
  assign bus.ALUEn      = alu_en;
  assign bus.RegWE      = reg_we;
  assign bus.Halted     = (state == ST_HALT);
  assign bus.Fault      = fault;
  assign bus.State      = state;

endmodule
`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
`default_nettype none
// ============================================================================
// tb_cpu_sequencer : instruction-level expected traces replayed cycle by cycle
// Revision: 1.0
// ============================================================================
module tb_cpu_sequencer;

  localparam int TO = 15;

  localparam int B_RD  = 10;
  localparam int B_WR  = 9;
  localparam int B_SEL = 8;
  localparam int B_IR  = 7;
  localparam int B_E   = 6;
  localparam int B_PCI = 5;
  localparam int B_PCL = 4;
  localparam int B_ALU = 3;
  localparam int B_RWE = 2;
  localparam int B_HLT = 1;
  localparam int B_FLT = 0;

  typedef struct {
    logic        rst;
    logic        run;
    logic [6:0]  op;
    logic        flt;
    logic        rdy;
    logic        brt;
    logic [2:0]  st;
    logic [10:0] outs;
    logic [10:0] mask;
    logic        chk_st;
  } cyc_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cpu_sequencer_if bus ();

  cpu_sequencer #(
    .MEM_TIMEOUT (TO)
  ) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus)
  );

  logic [10:0] obs;
  assign obs = {bus.MemRd, bus.MemWr, bus.MemAddrSel, bus.IRLoad, bus.E, bus.PCInc,
                bus.PCLoad, bus.ALUEn, bus.RegWE, bus.Halted, bus.Fault};

  cyc_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [10:0] bit1(input int b);
    logic [10:0] v;
    v    = '0;
    v[b] = 1'b1;
    return v;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [6:0] rop();
    return 7'($urandom_range(0, 127));
  endfunction

  task automatic push(input logic [2:0] st, input logic [10:0] outs, input logic rdy,
                      input logic run, input logic [6:0] op, input logic flt, input logic brt);
    cyc_t c;
    c.rst = 1'b0; c.run = run; c.op = op; c.flt = flt; c.rdy = rdy; c.brt = brt;
    c.st = st; c.outs = outs; c.mask = '1; c.chk_st = 1'b1;
    q.push_back(c);
  endtask

  // Reset cycle: strobes must be low; state and status flags only settle at the edge
  task automatic push_reset();
    cyc_t c;
    c.rst = 1'b1; c.run = rb(); c.op = rop(); c.flt = rb(); c.rdy = rb(); c.brt = rb();
    c.st = 3'd0; c.outs = '0; c.mask = ~(bit1(B_HLT) | bit1(B_FLT)); c.chk_st = 1'b0;
    q.push_back(c);
  endtask

  task automatic idle_start();
    push(3'd0, '0, rb(), 1'b1, rop(), rb(), rb());
  endtask

  task automatic halt_seq(input logic with_fault);
    logic [10:0] ho;
    ho = bit1(B_HLT) | (with_fault ? bit1(B_FLT) : 11'd0);
    repeat ($urandom_range(1, 3)) push(3'd6, ho, rb(), rb(), rop(), rb(), rb());
    push_reset();
    idle_start();
  endtask

  task automatic boundary(input logic run);
    if (!run) begin
      repeat ($urandom_range(0, 2)) push(3'd0, '0, rb(), 1'b0, rop(), rb(), rb());
      idle_start();
    end
  endtask

  // Expected trace of one instruction, starting in its first FETCH cycle
  task automatic gen_instr(input logic [6:0] op, input logic flt, input logic brt,
                           input int fwait, input int mwait, input logic run_end);
    logic [10:0] mo;
    logic        is_ld;
    if (fwait >= TO) begin
      repeat (TO) push(3'd1, bit1(B_RD), 1'b0, rb(), rop(), rb(), rb());
      push(3'd1, '0, 1'b0, rb(), rop(), rb(), rb());
      halt_seq(1'b1);
      return;
    end
    repeat (fwait) push(3'd1, bit1(B_RD), 1'b0, rb(), rop(), rb(), rb());
    push(3'd1, bit1(B_RD) | bit1(B_IR) | bit1(B_PCI), 1'b1, rb(), rop(), rb(), rb());
    push(3'd2, bit1(B_E), rb(), rb(), op, rb(), rb());
    if (flt || op > 7'd41) begin
      push(3'd3, '0, rb(), rb(), op, flt, brt);
      halt_seq(1'b1);
      return;
    end
    if (op <= 7'd8) begin
      push(3'd3, ((op == 7'd0) || (op == 7'd8) || brt) ? bit1(B_PCL) : 11'd0,
           rb(), run_end, op, flt, brt);
      boundary(run_end);
      return;
    end
    if (op == 7'd41) begin
      push(3'd3, '0, rb(), rb(), op, flt, brt);
      halt_seq(1'b0);
      return;
    end
    if (op <= 7'd32) begin
      push(3'd3, bit1(B_ALU), rb(), rb(), op, flt, brt);
    end else if (op >= 7'd35 && op <= 7'd38) begin
      push(3'd3, '0, rb(), rb(), op, flt, brt);
    end else begin
      push(3'd3, '0, rb(), rb(), op, flt, brt);
      is_ld = (op == 7'd33) || (op == 7'd39);
      mo    = bit1(B_SEL) | (is_ld ? bit1(B_RD) : bit1(B_WR));
      if (mwait >= TO) begin
        repeat (TO) push(3'd4, mo, 1'b0, rb(), rop(), rb(), rb());
        push(3'd4, '0, 1'b0, rb(), rop(), rb(), rb());
        halt_seq(1'b1);
        return;
      end
      repeat (mwait) push(3'd4, mo, 1'b0, rb(), rop(), rb(), rb());
      push(3'd4, mo, 1'b1, is_ld ? rb() : run_end, rop(), rb(), rb());
      if (!is_ld) begin
        boundary(run_end);
        return;
      end
    end
    push(3'd5, ((op == 7'd14) || (op == 7'd18)) ? 11'd0 : bit1(B_RWE),
         rb(), run_end, rop(), rb(), rb());
    boundary(run_end);
  endtask

  task automatic gen_abort();
    repeat ($urandom_range(1, 3)) push(3'd1, bit1(B_RD), 1'b0, rb(), rop(), rb(), rb());
    push_reset();
    idle_start();
  endtask

  initial begin
    logic [6:0] mops [4];
    logic [6:0] op;
    int         cls;
    mops = '{7'd33, 7'd34, 7'd39, 7'd40};

    push_reset();
    idle_start();
    gen_instr(7'd9,  1'b0, 1'b0, 2, 0, 1'b1);
    gen_instr(7'd1,  1'b0, 1'b0, 0, 0, 1'b1);
    gen_instr(7'd1,  1'b0, 1'b1, 0, 0, 1'b1);
    gen_instr(7'd34, 1'b0, 1'b0, 1, 2, 1'b1);
    gen_instr(7'd33, 1'b0, 1'b0, 0, 1, 1'b1);
    gen_instr(7'd14, 1'b0, 1'b0, 0, 0, 1'b1);
    gen_instr(7'd9,  1'b1, 1'b0, 0, 0, 1'b1);
    gen_instr(7'd41, 1'b0, 1'b0, 0, 0, 1'b1);
    gen_instr(7'd9,  1'b0, 1'b0, 0, 0, 1'b0);
    gen_instr(7'd9,  1'b0, 1'b0, TO, 0, 1'b1);
    gen_instr(7'd40, 1'b0, 1'b0, 0, TO, 1'b1);

    for (int k = 0; k < 120; k++) begin
      cls = $urandom_range(0, 9);
      case (cls)
        0, 1:    op = 7'($urandom_range(0, 8));
        2, 3:    op = 7'($urandom_range(9, 32));
        4:       op = 7'($urandom_range(35, 38));
        5, 6:    op = mops[$urandom_range(0, 3)];
        7:       op = 7'd41;
        8:       op = 7'($urandom_range(42, 127));
        default: op = rop();
      endcase
      if ($urandom_range(0, 24) == 0) gen_abort();
      else gen_instr(op, $urandom_range(0, 15) == 0, rb(),
                     ($urandom_range(0, 19) == 0) ? TO : int'($urandom_range(0, 4)),
                     ($urandom_range(0, 19) == 0) ? TO : int'($urandom_range(0, 4)),
                     $urandom_range(0, 3) != 0);
    end

    foreach (q[i]) begin
      rst         = q[i].rst;
      bus.Run     = q[i].run;
      bus.OP      = q[i].op;
      bus.FLT     = q[i].flt;
      bus.MemRdy  = q[i].rdy;
      bus.BrTaken = q[i].brt;
      @(negedge clk);
      if (q[i].chk_st) check_val($sformatf("cyc%0d_state", i), 32'(bus.State), 32'(q[i].st));
      check_val($sformatf("cyc%0d_strobes", i), 32'(obs & q[i].mask), 32'(q[i].outs & q[i].mask));
      @(posedge clk);
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
